// File: rtl/bj_result_collector_pkg.sv
// bj_result_collector_pkg
// Shared constants and FSM state types for the blackjack result collector.
//   FRAME_LEN  : bits per probability frame (MSB first)
//   PROB_MAX   : largest legal probability value (percent)
//   CNT_MAX    : saturation value of the win/tie tallies
//   WIN_*      : win_code values
//   p_state_e  : probability deserializer states
//   w_state_e  : winner decoder states
package bj_result_collector_pkg;

    localparam int unsigned FRAME_LEN = 7;
    localparam logic [6:0]  PROB_MAX  = 7'd100;
    localparam logic [7:0]  CNT_MAX   = 8'd255;

    localparam logic [1:0]  WIN_TIE   = 2'b00;
    localparam logic [1:0]  WIN_USER1 = 2'b01;
    localparam logic [1:0]  WIN_USER2 = 2'b10;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_SHIFT = 2'd1,
        P_GAP   = 2'd2
    } p_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_B1   = 2'd1,
        W_GAP  = 2'd2
    } w_state_e;

endpackage

// File: rtl/bj_deser7.sv
// bj_deser7
// 7-bit MSB-first serial-to-parallel shifter with bit counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift din in this cycle; when low the bit counter restarts
//   din        : serial data bit
//   word       : frame value including the bit currently on din
//   done       : en is high and din carries the last bit of the frame
module bj_deser7
    import bj_result_collector_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    output logic [FRAME_LEN-1:0] word,
    output logic                 done
);

    logic [FRAME_LEN-2:0] sr;
    logic [2:0]           cnt;

    // The completed word is presented in the same cycle as its last bit so
    // the parent can register it with a single cycle of latency.
    assign word = {sr, din};
    assign done = en && (cnt == 3'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else begin
            sr  <= {sr[FRAME_LEN-3:0], din};
            cnt <= done ? '0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/bj_result_collector.sv
// bj_result_collector
// Collects per-frame probabilities and game winners from the blackjack core.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clr                   : synchronous clear of tallies and prob_idx
//   out_valid1/equal/exceed : 7-cycle probability frames, MSB first
//   out_valid2/winner     : 1- or 2-cycle winner frames
//   prob_valid            : pulse, new p_equal/p_exceed/prob_err/prob_idx
//   p_equal, p_exceed     : last complete probability frame
//   prob_idx              : frame index within the current game
//   prob_err              : either probability above PROB_MAX
//   win_valid, win_code   : pulse and held decoded winner
//   win_cnt1/win_cnt2/tie_cnt : saturating tallies
//   frame_err             : pulse, any protocol violation
module bj_result_collector
    import bj_result_collector_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       out_valid1,
    input  logic       equal,
    input  logic       exceed,
    input  logic       out_valid2,
    input  logic       winner,
    output logic       prob_valid,
    output logic [6:0] p_equal,
    output logic [6:0] p_exceed,
    output logic [1:0] prob_idx,
    output logic       prob_err,
    output logic       win_valid,
    output logic [1:0] win_code,
    output logic [7:0] win_cnt1,
    output logic [7:0] win_cnt2,
    output logic [7:0] tie_cnt,
    output logic       frame_err
);

    p_state_e             p_state;
    w_state_e             w_state;
    logic                 w_b0;
    logic                 both_hi;
    logic                 shift_en;
    logic                 eq_done;
    logic                 ex_done;
    logic                 frame_done;
    logic [FRAME_LEN-1:0] eq_word;
    logic [FRAME_LEN-1:0] ex_word;
    logic                 dec_valid;
    logic                 dec_bad;
    logic [1:0]           dec_code;

    // Simultaneous strobes are a violation that aborts both decoders.
    assign both_hi  = out_valid1 & out_valid2;
    assign shift_en = out_valid1 && !both_hi &&
                      (p_state == P_IDLE || p_state == P_SHIFT);
    assign frame_done = eq_done & ex_done;

    bj_deser7 u_deser_equal (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (equal),
        .word  (eq_word),
        .done  (eq_done)
    );

    bj_deser7 u_deser_exceed (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (exceed),
        .word  (ex_word),
        .done  (ex_done)
    );

    // Winner decision made on the second W_B1 sample.
    always_comb begin
        dec_valid = 1'b0;
        dec_bad   = 1'b0;
        dec_code  = WIN_TIE;
        if (!both_hi && w_state == W_B1) begin
            if (!out_valid2 && !w_b0) begin
                dec_valid = 1'b1;
            end else if (out_valid2 && w_b0) begin
                dec_valid = 1'b1;
                dec_code  = {winner, ~winner};
            end else begin
                dec_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_IDLE;
            w_state    <= W_IDLE;
            w_b0       <= 1'b0;
            prob_valid <= 1'b0;
            p_equal    <= '0;
            p_exceed   <= '0;
            prob_idx   <= '0;
            prob_err   <= 1'b0;
            win_valid  <= 1'b0;
            win_code   <= WIN_TIE;
            win_cnt1   <= '0;
            win_cnt2   <= '0;
            tie_cnt    <= '0;
            frame_err  <= 1'b0;
        end else begin
            prob_valid <= 1'b0;
            win_valid  <= dec_valid;

            // Every violation source ORs into one registered pulse.
            frame_err <= both_hi || dec_bad ||
                         (p_state == P_SHIFT && !out_valid1) ||
                         (p_state == P_GAP   &&  out_valid1) ||
                         (w_state == W_GAP   &&  out_valid2);

            if (both_hi) begin
                p_state <= P_IDLE;
                w_state <= W_IDLE;
            end else begin
                case (p_state)
                    P_IDLE: begin
                        if (out_valid1) p_state <= P_SHIFT;
                    end
                    P_SHIFT: begin
                        if (!out_valid1) begin
                            p_state <= P_IDLE;
                        end else if (frame_done) begin
                            p_state    <= P_GAP;
                            prob_valid <= 1'b1;
                            p_equal    <= eq_word;
                            p_exceed   <= ex_word;
                            prob_err   <= (eq_word > PROB_MAX) || (ex_word > PROB_MAX);
                        end
                    end
                    P_GAP: begin
                        if (!out_valid1) p_state <= P_IDLE;
                    end
                    default: p_state <= P_IDLE;
                endcase

                case (w_state)
                    W_IDLE: begin
                        if (out_valid2) begin
                            w_b0    <= winner;
                            w_state <= W_B1;
                        end
                    end
                    W_B1: begin
                        w_state <= (dec_valid && out_valid2) ? W_GAP : W_IDLE;
                    end
                    W_GAP: begin
                        if (!out_valid2) w_state <= W_IDLE;
                    end
                    default: w_state <= W_IDLE;
                endcase
            end

            if (dec_valid) win_code <= dec_code;

            if (clr) begin
                win_cnt1 <= '0;
                win_cnt2 <= '0;
                tie_cnt  <= '0;
            end else if (dec_valid) begin
                case (dec_code)
                    WIN_USER1: if (win_cnt1 != CNT_MAX) win_cnt1 <= win_cnt1 + 8'd1;
                    WIN_USER2: if (win_cnt2 != CNT_MAX) win_cnt2 <= win_cnt2 + 8'd1;
                    default:   if (tie_cnt  != CNT_MAX) tie_cnt  <= tie_cnt  + 8'd1;
                endcase
            end

            // A decoded winner starts a new game, so the frame index restarts.
            if (clr || win_valid) begin
                prob_idx <= '0;
            end else if (prob_valid) begin
                prob_idx <= prob_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_bj_result_collector.sv
module tb_bj_result_collector;

    logic       clk = 1'b0;
    logic       rst_n, clr, out_valid1, equal, exceed, out_valid2, winner;
    logic       prob_valid, prob_err, win_valid, frame_err;
    logic [6:0] p_equal, p_exceed;
    logic [1:0] prob_idx, win_code;
    logic [7:0] win_cnt1, win_cnt2, tie_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: frames seen this game, tallies per outcome
    // (0 tie, 1 user1, 2 user2), last complete probability frame.
    int         exp_idx = 0;
    int         tally[3] = '{0, 0, 0};
    logic [6:0] last_eq = '0;
    logic [6:0] last_ex = '0;

    always #5 clk = ~clk;

    bj_result_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .out_valid1 (out_valid1),
        .equal      (equal),
        .exceed     (exceed),
        .out_valid2 (out_valid2),
        .winner     (winner),
        .prob_valid (prob_valid),
        .p_equal    (p_equal),
        .p_exceed   (p_exceed),
        .prob_idx   (prob_idx),
        .prob_err   (prob_err),
        .win_valid  (win_valid),
        .win_code   (win_code),
        .win_cnt1   (win_cnt1),
        .win_cnt2   (win_cnt2),
        .tie_cnt    (tie_cnt),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_tallies(input string tag);
        chk({tag, "_tie"},  tie_cnt,  tally[0]);
        chk({tag, "_cnt1"}, win_cnt1, tally[1]);
        chk({tag, "_cnt2"}, win_cnt2, tally[2]);
    endtask

    // Sends one 7-bit frame; with hold, out_valid1 stays high one extra
    // cycle into the gap, which is a violation.
    task automatic send_frame(input logic [6:0] e, input logic [6:0] x, input bit hold);
        for (int i = 6; i >= 0; i--) begin
            out_valid1 = 1'b1;
            equal      = e[i];
            exceed     = x[i];
            tick();
        end
        out_valid1 = hold;
        equal      = 1'b0;
        exceed     = 1'b0;
        chk("prob_valid_hi", prob_valid, 1);
        chk("p_equal",  p_equal,  e);
        chk("p_exceed", p_exceed, x);
        chk("prob_err", prob_err, (int'(e) > 100 || int'(x) > 100) ? 1 : 0);
        chk("prob_idx_at_valid", prob_idx, exp_idx);
        chk("frame_err_clean", frame_err, 0);
        last_eq = e;
        last_ex = x;
        tick();
        exp_idx = (exp_idx + 1) % 4;
        chk("prob_valid_lo", prob_valid, 0);
        chk("prob_idx_after", prob_idx, exp_idx);
        if (hold) begin
            chk("gap_frame_err", frame_err, 1);
            out_valid1 = 1'b0;
            tick();
            chk("gap_frame_err_clear", frame_err, 0);
        end
    endtask

    // o: 0 tie (one cycle, bit 0), 1 user1 ("10"), 2 user2 ("11").
    task automatic send_win(input int o, input bit with_clr);
        out_valid2 = 1'b1;
        winner     = (o != 0);
        tick();
        if (o == 0) out_valid2 = 1'b0;
        else        winner = (o == 2);
        clr = with_clr;
        tick();
        out_valid2 = 1'b0;
        winner     = 1'b0;
        clr        = 1'b0;
        if (with_clr) tally = '{0, 0, 0};
        else if (tally[o] < 255) tally[o]++;
        chk("win_valid_hi", win_valid, 1);
        chk("win_code", win_code, o);
        chk_tallies("win");
        tick();
        exp_idx = 0;
        chk("win_valid_lo", win_valid, 0);
        chk("win_frame_err", frame_err, 0);
        chk("prob_idx_win_reset", prob_idx, 0);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; out_valid1 = 1'b0; equal = 1'b0;
        exceed = 1'b0; out_valid2 = 1'b0; winner = 1'b0;
        #3;
        chk("rst_prob_valid", prob_valid, 0);
        chk("rst_p_equal", p_equal, 0);
        chk("rst_prob_idx", prob_idx, 0);
        chk("rst_win_code", win_code, 0);
        chk("rst_frame_err", frame_err, 0);
        chk_tallies("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed frames: 50/25, then an out-of-range equal value.
        send_frame(7'b0110010, 7'b0011001, 1'b0);
        send_frame(7'b1100101, 7'd40, 1'b0);
        send_frame(7'd100, 7'd100, 1'b0);

        // Random frames, including index wrap past 3.
        for (int n = 0; n < 8; n++) begin
            send_frame(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 1'b0);
        end

        // Directed winners then random ones.
        send_win(0, 1'b0);
        send_win(1, 1'b0);
        send_win(2, 1'b0);
        for (int n = 0; n < 10; n++) begin
            send_win(int'($urandom_range(0, 2)), 1'b0);
        end

        // Frame aborted after 4 bits.
        for (int i = 0; i < 4; i++) begin
            out_valid1 = 1'b1; equal = 1'b1; exceed = 1'b1;
            tick();
        end
        out_valid1 = 1'b0;
        tick();
        chk("abort_frame_err", frame_err, 1);
        chk("abort_prob_valid", prob_valid, 0);
        chk("abort_p_equal_held", p_equal, last_eq);
        chk("abort_p_exceed_held", p_exceed, last_ex);
        tick();
        chk("abort_frame_err_pulse", frame_err, 0);
        send_frame(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 1'b0);

        // Strobe held into the gap.
        send_frame(7'd33, 7'd66, 1'b1);
        send_frame(7'($urandom_range(0, 100)), 7'($urandom_range(0, 100)), 1'b0);

        // Both strobes together from idle.
        out_valid1 = 1'b1; out_valid2 = 1'b1; winner = 1'b0;
        tick();
        out_valid1 = 1'b0; out_valid2 = 1'b0;
        chk("both_frame_err", frame_err, 1);
        chk("both_win_valid", win_valid, 0);
        tick();
        chk("both_no_win", win_valid, 0);
        chk("both_no_prob", prob_valid, 0);
        send_win(2, 1'b0);

        // One-cycle winner frame with b0=1 is malformed.
        out_valid2 = 1'b1; winner = 1'b1;
        tick();
        out_valid2 = 1'b0; winner = 1'b0;
        tick();
        chk("bad_win_frame_err", frame_err, 1);
        chk("bad_win_valid", win_valid, 0);
        chk_tallies("bad_win");

        // Saturation of the user1 tally.
        for (int n = 0; n < 256; n++) send_win(1, 1'b0);
        chk("sat_cnt1", win_cnt1, 255);

        // Clear on its own, then coinciding with a decode.
        send_frame(7'd10, 7'd20, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tally = '{0, 0, 0};
        exp_idx = 0;
        chk_tallies("clr");
        chk("clr_prob_idx", prob_idx, 0);
        send_win(1, 1'b0);
        send_win(2, 1'b1);

        // Reset in the middle of a frame.
        send_frame(7'd77, 7'd12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            out_valid1 = 1'b1; equal = 1'b1; exceed = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        #1;
        tally = '{0, 0, 0};
        exp_idx = 0;
        chk("midrst_p_equal", p_equal, 0);
        chk("midrst_p_exceed", p_exceed, 0);
        chk("midrst_prob_idx", prob_idx, 0);
        chk("midrst_win_code", win_code, 0);
        chk_tallies("midrst");
        out_valid1 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(7'b0110010, 7'b0011001, 1'b0);
        send_win(0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
